// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the PWM peripheral.
// Used by both the timebase and the output stage.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam int NUM_OUT   = 16;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
  typedef logic [NUM_OUT-1:0]   out_vec_t;

  localparam pwm_cnt_t PWM_FULL_ON = 8'hFF;
  localparam pwm_cnt_t PWM_CNT_MAX = 8'hFF;

  // Full-on duty is special-cased so that 0xFF gives a solid high level.
  function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == PWM_FULL_ON) ? 1'b1 : (cnt < duty);
  endfunction

  // Output enable has priority over PWM select.
  function automatic out_vec_t out_mux(input out_vec_t en_out,
                                       input out_vec_t en_pwm,
                                       input logic     level);
    out_vec_t res;
    for (int i = 0; i < NUM_OUT; i++) begin
      res[i] = en_out[i] & (~en_pwm[i] | level);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM timebase with a double-buffered duty register.
// Produces the shared PWM level and a one-clk period_start strobe.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic     clk,
  input  logic     rst_n,
  input  pwm_cnt_t duty_req,
  output logic     pwm_level,
  output logic     period_start
);

  localparam int PRE_W = ($clog2(PRESCALE) > 0) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] prescaler;
  pwm_cnt_t         pwm_cnt;
  pwm_cnt_t         duty_active;
  logic             tick;
  logic             boundary;

  assign tick     = (prescaler == PRE_MAX);
  assign boundary = tick && (pwm_cnt == PWM_CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Duty is only sampled on the last clk of a period, so a period never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active  <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (boundary) begin
        duty_active <= duty_req;
      end
    end
  end

  assign pwm_level = pwm_compare(pwm_cnt, duty_active);

endmodule

// File: rtl/pwm_peripheral.sv
// Drives the 16 chip outputs from the enable registers and the shared PWM level.
// Each output is low, static high, or follows the PWM waveform.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  out_vec_t en_out;
  out_vec_t en_pwm;
  logic     pwm_level;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .duty_req    (pwm_duty_cycle),
    .pwm_level   (pwm_level),
    .period_start(period_start)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_mux(en_out, en_pwm, pwm_level);
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: a cycle-count reference model predicts
// every output update, and a separate monitor compares the DUT against it.
module tb_pwm_peripheral;

  localparam int PRESCALE = 13;
  localparam int PER      = PRESCALE * 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_out_lo = 8'hFF, en_out_hi = 8'hFF;
  logic [7:0]  en_pwm_lo = 8'hFF, en_pwm_hi = 8'hFF;
  logic [7:0]  duty = 8'hFF;
  logic [15:0] out;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  int          k = 0;
  int          m_duty = 0;

  pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_out_lo),
    .en_reg_out_15_8(en_out_hi),
    .en_reg_pwm_7_0 (en_pwm_lo),
    .en_reg_pwm_15_8(en_pwm_hi),
    .pwm_duty_cycle (duty),
    .out            (out),
    .period_start   (period_start)
  );

  always #5 clk = ~clk;

  // Reference model: k counts clk edges since reset release, so the count and
  // period position follow from plain division; duty loads on a period's last clk.
  always @(posedge clk) begin
    logic [15:0] eo, ep, e_out;
    logic        level, e_ps;
    int          cnt;
    if (!rst_n) begin
      k = 0;
      m_duty = 0;
      exp_q.push_back(17'h0);
    end else begin
      cnt   = (k / PRESCALE) % 256;
      level = (m_duty == 255) || (cnt < m_duty);
      eo = {en_out_hi, en_out_lo};
      ep = {en_pwm_hi, en_pwm_lo};
      for (int i = 0; i < 16; i++) begin
        e_out[i] = !eo[i] ? 1'b0 : (ep[i] ? level : 1'b1);
      end
      e_ps = ((k + 1) % PER) == 0;
      if ((k % PER) == PER - 1) m_duty = int'(duty);
      k++;
      exp_q.push_back({e_out, e_ps});
    end
  end

  // Monitor: every output update is popped and compared; period spacing is tracked too.
  initial begin
    logic [16:0] e;
    int cyc = 0;
    int last_ps = -1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_empty at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if ({out, period_start} !== e) begin
          errors++;
          $display("[TB] FAIL out_update cycle %0d: got out=%h ps=%b, expected out=%h ps=%b",
                   cyc, out, period_start, e[16:1], e[0]);
        end
      end
      if (!rst_n) begin
        last_ps = -1;
      end else if (period_start) begin
        if (last_ps >= 0) begin
          checks++;
          if (cyc - last_ps != PER) begin
            errors++;
            $display("[TB] FAIL period_spacing: got %0d, expected %0d", cyc - last_ps, PER);
          end
        end
        last_ps = cyc;
      end
    end
  end

  task automatic apply_stimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_out_hi, en_out_lo} = eo;
    {en_pwm_hi, en_pwm_lo} = ep;
    duty = d;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_ps(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * PER + 4 && !seen; i++) begin
      @(negedge clk);
      if (period_start) seen = 1'b1;
    end
    check_output(name, int'(seen), 1);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out[0]) hi++;
    end
  endtask

  initial begin
    int h1, h2, h3;
    $display("[TB] start, PRESCALE=%0d period=%0d", PRESCALE, PER);

    // Reset held with every input at 0xFF
    repeat (4) @(negedge clk);
    check_output("reset_out", int'(out), 0);
    check_output("reset_ps", int'(period_start), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_reset_out", int'(out), 0);
    check_output("post_reset_ps", int'(period_start), 0);

    // Static enables
    apply_stimulus(16'h8001, 16'h0000, 8'h00);
    repeat (2) @(negedge clk);
    check_output("static_8001", int'(out), 16'h8001);
    en_out_hi = 8'h00;
    repeat (2) @(negedge clk);
    check_output("static_0001", int'(out), 16'h0001);

    // 50% duty
    apply_stimulus(16'h0001, 16'h0001, 8'h80);
    wait_ps("ps_50");
    count_high(PER, h1);
    check_output("high_50pct", h1, 128 * PRESCALE);

    // Duty extremes
    duty = 8'h00;
    wait_ps("ps_0");
    count_high(PER, h1);
    check_output("high_0pct", h1, 0);
    duty = 8'hFF;
    wait_ps("ps_ff");
    count_high(2 * PER, h1);
    check_output("high_100pct_2per", h1, 2 * PER);

    // Mid-period duty update is deferred to the next period
    duty = 8'h40;
    wait_ps("ps_40");
    count_high(16 * PRESCALE, h1);
    duty = 8'hC0;
    count_high(PER - 16 * PRESCALE, h2);
    check_output("high_current_40", h1 + h2, 64 * PRESCALE);
    count_high(PER, h3);
    check_output("high_next_c0", h3, 192 * PRESCALE);

    // Reset mid-period with out[0] high
    duty = 8'h40;
    wait_ps("ps_pre_reset");
    wait_ps("ps_pre_reset2");
    count_high(48 * PRESCALE, h1);
    check_output("pre_reset_out0", int'(out[0]), 1);
    rst_n = 1'b0;
    #1;
    check_output("async_reset_out", int'(out), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_high(PER, h1);
    check_output("first_period_low", h1, 0);
    count_high(PER, h2);
    check_output("resume_duty_40", h2, 64 * PRESCALE);

    // Randomized enables and duty writes at arbitrary times
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(16'($urandom), 16'($urandom), 8'($urandom));
      repeat ($urandom_range(1, 500)) @(negedge clk);
    end
    duty = 8'($urandom_range(1, 254));
    repeat (PER + 20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register file. Takes the five 8-bit control registers (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. Each output is forced low, held static high, or driven by one shared PWM waveform. The waveform comes from a prescaled 8-bit timebase, and duty updates are double-buffered so they never glitch mid-period.

Parameters:
PRESCALE, 13, clk cycles per PWM count step (>=1); PWM period = PRESCALE*256 clk (~3.0 kHz at 10 MHz)
PRE_W, $clog2(PRESCALE)>0 ? $clog2(PRESCALE) : 1, prescaler counter width (derived, not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_reg_out_7_0  input  8  output enable, bits 7:0
en_reg_out_15_8  input  8  output enable, bits 15:8
en_reg_pwm_7_0  input  8  PWM select, bits 7:0
en_reg_pwm_15_8  input  8  PWM select, bits 15:8
pwm_duty_cycle  input  8  requested duty (0x00 = 0%, 0xFF = 100%)
out  output  16  chip outputs ({15_8, 7_0} ordering)
period_start  output  1  one-clk strobe on the first clk of each PWM period

Behaviour:
- Reset (async assert, sync-to-clk release):
  - out = 16'h0000, period_start = 0.
  - Prescaler = 0, pwm_cnt = 0, duty_active = 8'h00.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick = (prescaler == PRESCALE-1).
  - PRESCALE = 1 gives tick on every clk.
- pwm_cnt (8-bit):
  - Increments on tick and wraps 255 -> 0.
  - Each value holds for exactly PRESCALE clk, including value 0 immediately after reset.
- Period boundary:
  - boundary = tick && pwm_cnt == 8'hFF.
  - On boundary: duty_active <= pwm_duty_cycle, and period_start is registered high for the next clk only.
  - Duty writes at any other time are ignored until the next boundary. The last value present at the boundary wins.
- PWM level (combinational from registered state):
  - duty_active == 8'hFF -> 1.
  - Otherwise pwm_cnt < duty_active.
  - duty 0x00 -> never high. Duty N (N < 255) -> high for N*PRESCALE clk per period, starting at pwm_cnt 0.
- Output mux, per bit i, registered:
  - out[i] <= !en_out[i] ? 0 : (en_pwm[i] ? pwm_level : 1).
  - en_out has priority: a bit with PWM selected but output disabled stays 0.
- Latency:
  - Enable change -> out reflects it on the 2nd rising clk edge after the input changes (one output register stage). Inputs are already clk-domain registers.
  - pwm_cnt transition -> out follows 1 clk later.
- Simultaneous events: an enable change on the boundary cycle uses the new enable with the old-period pwm_level in that same out update. No special case.
- Reset mid-period: out drops to 0 immediately (async). After release the timebase restarts at count 0 with duty_active = 0. PWM outputs stay low for the whole first period and take the programmed duty from the following period.

Decomposition:
- Shared package pwm_pkg:
  - PWM_CNT_W = 8.
  - PWM_FULL_ON = 8'hFF.
  - NUM_OUT = 16.
- Sub-module pwm_timebase holds prescaler, pwm_cnt, boundary/period_start and duty_active. Output: pwm_level, period_start.
- The top holds only the 16-bit enable concatenation and the registered output mux.

Test Plan (PRESCALE = 13, period = 3328 clk):
1. Reset: assert rst_n=0 with all inputs 0xFF -> out = 0x0000, period_start = 0 during reset and on the first clk after release.
2. Static enables: en_out = 0x8001, en_pwm = 0x0000 -> out = 0x8001 by the 2nd clk edge; set en_out_15_8 = 0 -> out = 0x0001.
3. 50% duty:
   - Stimulus: en_out_7_0 = 0x01, en_pwm_7_0 = 0x01, duty = 0x80.
   - After the first period_start: out[0] high exactly 1664 clk, then low 1664 clk, repeating.
   - period_start pulses every 3328 clk.
4. Duty extremes: duty = 0x00 -> out[0] low for a full period. duty = 0xFF -> out[0] high with no low clk across 2 periods.
5. Mid-period update: duty = 0x40 active; write 0xC0 at pwm_cnt = 0x10 -> current period high 832 clk, next period high 2496 clk.
6. Reset mid-operation: pull rst_n low at pwm_cnt = 0x30 with out[0] high -> out = 0 asynchronously. After release, out[0] stays low for the first period, then resumes at the programmed duty.
